// File: rtl/gate_exer_pkg.sv
// rtl/gate_exer_pkg.sv - shared types and constants for gate_exerciser (GATE_EXER_SYNC_EN selects SYNC_DEPTH)
package gate_exer_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_VECTORS = 4;

`ifdef GATE_EXER_SYNC_EN
    localparam int SYNC_DEPTH = 2;
`else
    localparam int SYNC_DEPTH = 0;
`endif

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - generic 1-bit two-stage synchroniser with asynchronous active-high reset
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/gate_exerciser.sv
// rtl/gate_exerciser.sv - sweeps a 2-input gate through all vectors and checks y against GATE_FN
// GATE_EXER_SYNC_EN: route y_in through sync_2ff (window grows by two cycles).
module gate_exerciser
    import gate_exer_pkg::*;
#(
    parameter logic [3:0] GATE_FN       = 4'b1000,
    parameter int         SETTLE_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       y_in,
    output logic       a_out,
    output logic       b_out,
    output logic       busy,
    output logic       done,
    output logic       pass,
    output logic [3:0] fail_vec
);

    localparam int             W      = SETTLE_CYCLES + SYNC_DEPTH;
    localparam int             CW     = $clog2(W + 1);
    localparam logic [CW-1:0]  RELOAD = CW'(W - 1);
    localparam logic [1:0]     LAST_K = 2'(NUM_VECTORS - 1);

    logic y_s;

`ifdef GATE_EXER_SYNC_EN
    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (y_in),
        .q   (y_s)
    );
`else
    assign y_s = y_in;
`endif

    state_t          state_q, state_d;
    logic [1:0]      k_q, k_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            a_q, a_d;
    logic            b_q, b_d;
    logic            pass_q, pass_d;
    logic [3:0]      fail_q, fail_d;
    logic [3:0]      fail_upd;
    logic [1:0]      k_nxt;

    always_comb begin
        state_d  = state_q;
        k_d      = k_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        pass_d   = pass_q;
        fail_d   = fail_q;
        fail_upd = fail_q;
        k_nxt    = k_q + 2'd1;

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = RUN;
                    k_d     = 2'd0;
                    cnt_d   = RELOAD;
                    a_d     = 1'b0;
                    b_d     = 1'b0;
                    fail_d  = 4'b0000;
                    pass_d  = 1'b0;
                end
            end
            RUN: begin
                if (cnt_q == '0) begin
                    if (y_s != GATE_FN[k_q]) begin
                        fail_upd[k_q] = 1'b1;
                    end
                    fail_d = fail_upd;
                    if (k_q == LAST_K) begin
                        // pass must include the vector-3 result just folded in
                        state_d = DONE;
                        pass_d  = ~|fail_upd;
                        a_d     = 1'b0;
                        b_d     = 1'b0;
                    end else begin
                        k_d   = k_nxt;
                        cnt_d = RELOAD;
                        a_d   = k_nxt[1];
                        b_d   = k_nxt[0];
                    end
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            k_q     <= 2'd0;
            cnt_q   <= '0;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            pass_q  <= 1'b0;
            fail_q  <= 4'b0000;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            pass_q  <= pass_d;
            fail_q  <= fail_d;
        end
    end

    assign a_out    = a_q;
    assign b_out    = b_q;
    assign busy     = (state_q == RUN);
    assign done     = (state_q == DONE);
    assign pass     = pass_q;
    assign fail_vec = fail_q;

endmodule
